// File: rtl/phy_rx_align_ctrl.sv
// Receive word-alignment controller: hunts for the COMMA symbol, issues bit-slips while hunting,
// declares lock after a run of commas and forwards payload bytes while locked.
`timescale 1ns/1ps

module phy_rx_align_ctrl #(
    parameter logic [7:0] COMMA         = 8'hBC,
    parameter int         LOCK_COUNT    = 4,
    parameter int         SLIP_WAIT     = 8,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         COMMA_TIMEOUT = 64
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       force_resync,
    output logic       slip_req,
    output logic       locked,
    output logic       lock_lost,
    output logic       valid_out,
    output logic [7:0] data_out,
    output logic [3:0] slip_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [7:0] HUNT_LAST   = 8'(SLIP_WAIT - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LOCK_LAST   = 4'(LOCK_COUNT - 1);
    localparam logic [7:0] TO_LAST     = 8'(COMMA_TIMEOUT - 1);

    state_t     state, state_n;
    logic [7:0] hunt_cnt, hunt_n;
    logic [3:0] settle_cnt, settle_n;
    logic [3:0] comma_cnt, comma_n;
    logic [7:0] to_cnt, to_n;
    logic [3:0] slip_count_n;
    logic       slip_n, lost_n, valid_n, locked_n;
    logic       is_comma;

    assign is_comma = (rx_byte == COMMA);

    // Every output is computed here from pre-edge state and registered below.
    always_comb begin
        state_n      = state;
        hunt_n       = hunt_cnt;
        settle_n     = settle_cnt;
        comma_n      = comma_cnt;
        to_n         = to_cnt;
        slip_count_n = slip_count;
        slip_n       = 1'b0;
        lost_n       = 1'b0;
        valid_n      = 1'b0;

        if (force_resync) begin
            state_n  = HUNT;
            hunt_n   = '0;
            settle_n = '0;
            comma_n  = '0;
            to_n     = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (is_comma) begin
                        state_n = CHECK;
                        comma_n = 4'd1;
                        hunt_n  = '0;
                    end else if (hunt_cnt == HUNT_LAST) begin
                        state_n      = SETTLE;
                        slip_n       = 1'b1;
                        slip_count_n = slip_count + 4'd1;
                        settle_n     = '0;
                        hunt_n       = '0;
                    end else begin
                        hunt_n = hunt_cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    // The deserializer output is unstable right after a slip, so commas are ignored.
                    if (settle_cnt == SETTLE_LAST) begin
                        state_n = HUNT;
                        hunt_n  = '0;
                    end else begin
                        settle_n = settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (is_comma) begin
                        if (comma_cnt == LOCK_LAST) begin
                            state_n = LOCKED;
                            comma_n = '0;
                            to_n    = '0;
                        end else begin
                            comma_n = comma_cnt + 4'd1;
                        end
                    end else begin
                        state_n = HUNT;
                        comma_n = '0;
                        hunt_n  = '0;
                    end
                end
                LOCKED: begin
                    if (is_comma) begin
                        to_n = '0;
                    end else if (to_cnt == TO_LAST) begin
                        state_n = HUNT;
                        lost_n  = 1'b1;
                        to_n    = '0;
                        hunt_n  = '0;
                    end else begin
                        to_n    = to_cnt + 8'd1;
                        valid_n = 1'b1;
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end

        locked_n = (state_n == LOCKED);
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            hunt_cnt   <= '0;
            settle_cnt <= '0;
            comma_cnt  <= '0;
            to_cnt     <= '0;
            slip_req   <= 1'b0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            slip_count <= '0;
        end else begin
            state      <= state_n;
            hunt_cnt   <= hunt_n;
            settle_cnt <= settle_n;
            comma_cnt  <= comma_n;
            to_cnt     <= to_n;
            slip_req   <= slip_n;
            locked     <= locked_n;
            lock_lost  <= lost_n;
            valid_out  <= valid_n;
            data_out   <= rx_byte;
            slip_count <= slip_count_n;
        end
    end

endmodule

// File: tb/tb_phy_rx_align_ctrl.sv
// Scoreboard bench for phy_rx_align_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops one per clock edge and compares against the registered outputs.
`timescale 1ns/1ps

module tb_phy_rx_align_ctrl;

    logic       clk_f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       force_resync = 1'b0;
    logic       slip_req, locked, lock_lost, valid_out;
    logic [7:0] data_out;
    logic [3:0] slip_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] vec;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    phy_rx_align_ctrl dut (
        .clk_f       (clk_f),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .force_resync(force_resync),
        .slip_req    (slip_req),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .slip_count  (slip_count)
    );

    always #5 clk_f = ~clk_f;

    function automatic logic [15:0] pack_out(input logic s, input logic l, input logic ll,
                                             input logic v, input logic [7:0] d, input logic [3:0] c);
        return {s, l, ll, v, d, c};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got slip=%b locked=%b lost=%b valid=%b data=%h cnt=%0d, expected slip=%b locked=%b lost=%b valid=%b data=%h cnt=%0d",
                     tag, act[15], act[14], act[13], act[12], act[11:4], act[3:0],
                     exp[15], exp[14], exp[13], exp[12], exp[11:4], exp[3:0]);
        end
    endtask

    // Drive one byte for the next rising edge and queue the outputs that edge must produce.
    task automatic applyStimulus(input logic [7:0] b, input logic fr,
                                 input logic es, input logic el, input logic ell, input logic ev,
                                 input logic [3:0] ec, input string tag);
        exp_t e;
        @(negedge clk_f);
        rx_byte      = b;
        force_resync = fr;
        e.vec = pack_out(es, el, ell, ev, b, ec);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_f);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e.tag, pack_out(slip_req, locked, lock_lost, valid_out, data_out, slip_count), e.vec);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [3:0] cnt_before, cnt_after;

        #12;
        checkOutput("reset_state", pack_out(slip_req, locked, lock_lost, valid_out, data_out, slip_count), 16'h0000);
        @(posedge clk_f);
        #2 reset = 1'b0;

        // Constant hunting: slip at every 8th hunt edge, two ignored settle cycles, 16 slips wrap the count.
        for (int s = 1; s <= 16; s++) begin
            cnt_before = 4'(s - 1);
            cnt_after  = 4'(s);
            for (int i = 0; i < 10; i++) begin
                applyStimulus((i >= 8) ? 8'hBC : 8'h00, 1'b0, (i == 7), 1'b0, 1'b0, 1'b0,
                              (i >= 7) ? cnt_after : cnt_before, "hunt_slip");
            end
        end

        // Lock on four commas, then payload/comma/payload.
        for (int i = 0; i < 3; i++) applyStimulus(8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "lock_seq");
        applyStimulus(8'hBC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "lock_4th");
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, "data_55");
        applyStimulus(8'hBC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "comma_not_valid");
        applyStimulus(8'hA7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, "data_A7");

        applyStimulus(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "force_resync");

        // A broken comma run drops back to HUNT without a slip.
        applyStimulus(8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "broken_run");
        applyStimulus(8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "broken_run");
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "broken_run_no_slip");
        for (int i = 0; i < 3; i++) applyStimulus(8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "relock_seq");
        applyStimulus(8'hBC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "relock_7th");

        // A comma at the 63rd byte restarts the timeout; then a full timeout.
        for (int i = 0; i < 62; i++) applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, "payload_pre");
        applyStimulus(8'hBC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "timeout_restart");
        for (int i = 0; i < 63; i++) applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, "payload");
        applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, "timeout_edge");
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "after_timeout");

        // Relock, start a packet, then hit async reset between clock edges.
        for (int i = 0; i < 3; i++) applyStimulus(8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "lock_again");
        applyStimulus(8'hBC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "lock_again_4th");
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, "pre_reset_data");
        @(posedge clk_f);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset", pack_out(slip_req, locked, lock_lost, valid_out, data_out, slip_count), 16'h0000);
        @(posedge clk_f);
        #2 reset = 1'b0;

        // Hunt counter restarts from zero after reset.
        for (int i = 0; i < 8; i++)
            applyStimulus(8'h00, 1'b0, (i == 7), 1'b0, 1'b0, 1'b0, (i == 7) ? 4'd1 : 4'd0, "post_reset_hunt");
        applyStimulus(8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "post_reset_settle");

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk_f);
        #2;
        checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phy_rx_align_ctrl.md
Name: phy_rx_align_ctrl

Overview:
Receive-side word-alignment controller for the PHY deserializer, clocked in the byte (clk_f) domain. Monitors each deserialized byte for the COMMA idle symbol and declares lock after LOCK_COUNT consecutive commas. While hunting, it sequences the deserializer by pulsing a bit-slip request. Once locked, it forwards non-comma bytes as valid data and drops lock when commas stop arriving.

Parameters:
COMMA, 8'hBC, idle/alignment symbol
LOCK_COUNT, 4, consecutive commas required for lock (2..15)
SLIP_WAIT, 8, HUNT cycles without a comma before a slip request (2..255)
SETTLE_CYCLES, 2, cycles ignored after a slip request (1..15)
COMMA_TIMEOUT, 64, LOCKED cycles without a comma before lock loss (2..255)

Ports:
clk_f  input  1  byte clock
reset  input  1  asynchronous, active-high reset
rx_byte  input  8  deserialized byte, sampled every clk_f edge
force_resync  input  1  synchronous request to return to HUNT
slip_req  output  1  one-cycle pulse; deserializer shifts its bit boundary by one
locked  output  1  high while the state is LOCKED
lock_lost  output  1  one-cycle pulse on a COMMA_TIMEOUT loss
valid_out  output  1  data_out carries a payload byte
data_out  output  8  registered copy of rx_byte
slip_count  output  4  slips issued since reset; wraps at 15->0

Behaviour:
- Reset (async, high): state=HUNT; all counters 0; slip_req=0, locked=0, lock_lost=0, valid_out=0, data_out=0, slip_count=0.
- All outputs are registered. Decisions use the state and counters held before the edge.
- States: HUNT, SETTLE, CHECK, LOCKED.
- HUNT:
  - If rx_byte==COMMA: go to CHECK with comma_cnt=1 and hunt_cnt=0.
  - Otherwise, if hunt_cnt==SLIP_WAIT-1: slip_req<=1 for one cycle, slip_count++, go to SETTLE with settle_cnt=0.
  - Otherwise: hunt_cnt++.
- SETTLE:
  - rx_byte is ignored, including commas.
  - When settle_cnt==SETTLE_CYCLES-1: go to HUNT with hunt_cnt=0.
  - Otherwise: settle_cnt++.
- CHECK:
  - If rx_byte==COMMA and comma_cnt==LOCK_COUNT-1: go to LOCKED and set locked<=1 at this same edge.
  - If rx_byte==COMMA with any other comma_cnt: comma_cnt++.
  - If rx_byte!=COMMA: go to HUNT with comma_cnt=0 and hunt_cnt=0. No slip is issued.
- LOCKED:
  - If rx_byte==COMMA: to_cnt<=0.
  - Otherwise, if to_cnt==COMMA_TIMEOUT-1: go to HUNT, locked<=0, lock_lost<=1 for one cycle.
  - Otherwise: to_cnt++.
- Data path:
  - data_out<=rx_byte every edge.
  - valid_out<=1 only if the pre-edge state is LOCKED, rx_byte!=COMMA, force_resync==0 and no timeout fires on this edge; otherwise valid_out<=0.
  - Latency is one cycle. Commas are never valid.
- force_resync:
  - Overrides everything from any state: next state is HUNT, all counters 0, locked<=0, valid_out<=0.
  - No lock_lost pulse. No slip is issued on that edge.
- slip_req and lock_lost are never high in the same cycle.
- Reset asserted mid-operation aborts immediately and asynchronously to the reset values; there is no pending slip or lost-lock pulse afterwards.

Test Plan:
- Reset, then rx_byte=00 for 3 cycles -> all outputs 0, state HUNT; slip_req stays 0 until cycle 8.
- BC,BC,BC,BC,55,BC,A7 -> locked=1 at the edge sampling the 4th BC; valid_out=1/data_out=55 one edge after 55 is sampled; BC gives valid_out=0; A7 gives valid_out=1.
- BC,BC,00,BC,BC,BC,BC -> returns to HUNT after 00 with no slip; locked=1 only at the edge sampling the 7th byte.
- Constant 00 -> slip_req one-cycle pulse at the 8th edge and slip_count=1; BC during the next 2 cycles is ignored; the 2nd slip comes 8 cycles after SETTLE ends (slip_count=2); 16 slips wrap slip_count to 0.
- Locked, then 64 bytes of 11 -> valid_out=1 for the first 63 and 0 for the 64th; locked=0 and lock_lost=1 pulse at the 64th edge; a BC at cycle 63 instead resets the timeout.
- Locked, then force_resync=1 for one cycle -> locked=0, valid_out=0, no lock_lost; async reset asserted mid-packet -> outputs 0 immediately without waiting for a clock edge.
